// File: rtl/foo_bar_monitor.sv
// rtl/foo_bar_monitor.sv - checker for the foo/bar periodic pulse generator
// Optional macro FOO_BAR_MON_ERR_HOLD_EN: halt and freeze on the first error.
module foo_bar_monitor #(
    parameter int FOO_PERIOD = 2,
    parameter int BAR_PERIOD = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             foo_i,
    input  logic             bar_i,
    output logic             active_o,
    output logic [CNT_W-1:0] foo_cnt_o,
    output logic [CNT_W-1:0] bar_cnt_o,
    output logic [CNT_W-1:0] both_cnt_o,
    output logic             err_o,
    output logic [3:0]       err_code_o
);

    localparam int FW = $clog2(FOO_PERIOD + 1);
    localparam int BW = $clog2(BAR_PERIOD + 1);

`ifdef FOO_BAR_MON_ERR_HOLD_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t           state_q, state_d;
    logic [FW-1:0]    ph_foo_q, ph_foo_d;
    logic [BW-1:0]    ph_bar_q, ph_bar_d;
    logic [CNT_W-1:0] foo_cnt_q, foo_cnt_d;
    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [CNT_W-1:0] both_cnt_q, both_cnt_d;
    logic [3:0]       err_q, err_d;
    logic             active_q, active_d;
    logic             err_flag_q, err_flag_d;
    logic             foo_exp, bar_exp;
    logic [3:0]       err_set;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        ph_foo_d   = ph_foo_q;
        ph_bar_d   = ph_bar_q;
        foo_cnt_d  = foo_cnt_q;
        bar_cnt_d  = bar_cnt_q;
        both_cnt_d = both_cnt_q;
        err_d      = err_q;
        foo_exp    = (ph_foo_q == FW'(FOO_PERIOD));
        bar_exp    = (ph_bar_q == BW'(BAR_PERIOD));
        err_set    = {~bar_exp & bar_i, bar_exp & ~bar_i,
                      ~foo_exp & foo_i, foo_exp & ~foo_i};
        if (start_i) begin
            // Restart from any state; inputs in the start cycle are not checked.
            state_d    = RUN;
            ph_foo_d   = FW'(1);
            ph_bar_d   = BW'(1);
            foo_cnt_d  = '0;
            bar_cnt_d  = '0;
            both_cnt_d = '0;
            err_d      = '0;
        end else if (state_q == RUN) begin
            ph_foo_d = foo_exp ? FW'(1) : ph_foo_q + FW'(1);
            ph_bar_d = bar_exp ? BW'(1) : ph_bar_q + BW'(1);
            if (foo_exp && foo_i)
                foo_cnt_d = sat_inc(foo_cnt_q);
            if (bar_exp && bar_i)
                bar_cnt_d = sat_inc(bar_cnt_q);
            if (foo_exp && foo_i && bar_exp && bar_i)
                both_cnt_d = sat_inc(both_cnt_q);
            err_d = err_q | err_set;
`ifdef FOO_BAR_MON_ERR_HOLD_EN
            if (|err_set)
                state_d = HALT;
`endif
        end
        active_d   = (state_d == RUN);
        err_flag_d = |err_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ph_foo_q   <= FW'(1);
            ph_bar_q   <= BW'(1);
            foo_cnt_q  <= '0;
            bar_cnt_q  <= '0;
            both_cnt_q <= '0;
            err_q      <= '0;
            active_q   <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_foo_q   <= ph_foo_d;
            ph_bar_q   <= ph_bar_d;
            foo_cnt_q  <= foo_cnt_d;
            bar_cnt_q  <= bar_cnt_d;
            both_cnt_q <= both_cnt_d;
            err_q      <= err_d;
            active_q   <= active_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign active_o   = active_q;
    assign foo_cnt_o  = foo_cnt_q;
    assign bar_cnt_o  = bar_cnt_q;
    assign both_cnt_o = both_cnt_q;
    assign err_code_o = err_q;
    assign err_o      = err_flag_q;

endmodule
